booth_ctrl: RTL and testbench
=============================

BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 Parameter N_BIT, default `N_BIT from config.sv (8), operand width; the iteration count equals N_BIT.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: Clock (input, 1) and nReset (input, 1).
REQ-003 Clock  input  1  rising-edge system clock.
REQ-004 nReset  input  1  asynchronous active-low reset.
REQ-005 Start  input  1  host request to begin one multiply; the datapath operands are stable while Busy=1.
REQ-006 Q_out  input  3  datapath multiplier LSBs; Q_out[1:0] = {Q0, Q-1}; Q_out[2] SHALL be ignored.
REQ-007 Request  output  1  datapath control; see REQ-012.
REQ-008 Done  output  1  datapath control; see REQ-012.
REQ-009 add_s / sub_s / ashift_s  output  1 each  datapath add-multiplicand / subtract-multiplicand / arithmetic-right-shift strobes.
REQ-010 Busy  output  1  high from LOAD through SHIFT inclusive.
REQ-011 Valid  output  1  one-cycle pulse; the datapath Result is final in this cycle.

Function
REQ-012 Control encoding per state:
- IDLE: Request=0, Done=1.
- LOAD: Request=1, Done=1; the datapath loads op1/op2 and clears the accumulator.
- EVAL, SHIFT: Request=1, Done=0.
- FIN: Request=0, Done=1.
REQ-013 States SHALL be IDLE, LOAD, EVAL, SHIFT, FIN, with registered state and next-state logic.
REQ-014 Transitions:
- IDLE -> LOAD when Start=1 at the clock edge; otherwise stay in IDLE.
- LOAD -> EVAL.
- EVAL -> SHIFT.
- SHIFT -> EVAL while the iteration counter is nonzero after decrement; SHIFT -> FIN when it reaches zero.
- FIN -> IDLE unconditionally.
REQ-015 Iteration counter width $clog2(N_BIT+1): loaded with N_BIT in LOAD, decremented once per SHIFT cycle.
REQ-016 In EVAL only (Mealy decode of Q_out[1:0]): 2'b01 -> add_s=1; 2'b10 -> sub_s=1; 2'b00 and 2'b11 -> no strobe.
REQ-017 add_s and sub_s SHALL never be high together, and SHALL be 0 outside EVAL.
REQ-018 ashift_s=1 exactly in SHIFT and 0 in all other states.
REQ-019 Latency: with Start sampled at edge k, FIN occupies cycle k+2+2*N_BIT (k+18 for N_BIT=8); Valid=1 only in FIN.
REQ-020 Start while Busy=1 or in FIN SHALL be ignored; no queuing.
REQ-021 Start held high continuously SHALL cause back-to-back operations with exactly one IDLE cycle between FIN and the next LOAD.
REQ-022 Exactly N_BIT EVAL and N_BIT ashift_s cycles per operation, independent of the operand values.

Reset
REQ-023 nReset=0 SHALL force, immediately and regardless of the clock:
- state=IDLE and counter=0;
- add_s=sub_s=ashift_s=Request=Busy=Valid=0;
- Done=1.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no further strobes; after release the block waits in IDLE for a new Start.

Structure
REQ-025 Package booth_pkg SHALL hold the state enum (booth_state_t) and the Q-pair decode constants; N_BIT continues to come from config.sv.
REQ-026 The iteration counter SHALL be the sub-module booth_cnt (load, decrement, zero flag); the FSM and strobe decode stay in booth_ctrl.

Verification
REQ-027 Reset: nReset=0 mid-EVAL -> all strobes 0, Done=1 and Busy=0 asynchronously; after release the block stays in IDLE until Start.
REQ-028 Closed loop with mult, op1=8'd15, op2=8'd23, one Start pulse -> Valid at cycle k+18 with Result=16'd345; 8 ashift_s pulses counted.
REQ-029 Closed loop with op1=-8'sd15, op2=8'd23 -> Result=-16'sd345 (16'hFEA7); op1=-128, op2=-128 -> Result=16'h4000.
REQ-030 Open loop, Q_out forced to 01, 10, 00, 11 in successive EVAL cycles -> add_s, sub_s, none, none respectively; never both strobes high.
REQ-031 Start pulsed again during EVAL -> ignored: a single Valid and one operation only.
REQ-032 Start held high for 40 cycles -> Valid at k+18 and k+37, with one IDLE cycle between FIN and the next LOAD.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier controller.
package booth_pkg;

  // Controller states; LOAD through SHIFT are the busy window.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    FIN   = 3'd4
  } booth_state_t;

  // Decode of the multiplier pair {Q0, Q-1}; 00 and 11 need no arithmetic.
  localparam logic [1:0] QP_ADD = 2'b01;
  localparam logic [1:0] QP_SUB = 2'b10;

  // Width needed to hold an iteration count of n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/booth_cnt.sv
// Iteration counter: loads the operand width, counts down once per shift.
module booth_cnt
  import booth_pkg::*;
#(
  parameter int N_BIT = 8,
  parameter int CNT_W = cnt_width(N_BIT)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             i_load,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  // Load takes priority; decrement saturates at zero so a stray strobe cannot wrap.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(N_BIT);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
  // The count reaches zero after this decrement: the current shift is the final one.
  assign o_last  = (r_count == CNT_W'(1));

endmodule

// File: rtl/config.sv
// Project-wide build configuration: default operand width for the Booth multiplier.
`ifndef N_BIT
`define N_BIT 8
`endif

// File: rtl/booth_ctrl.sv
// Booth radix-2 multiplier controller: sequences LOAD, N_BIT x (EVAL, SHIFT), FIN.
`ifndef N_BIT
`define N_BIT 8
`endif

module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N_BIT = `N_BIT
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Start,
  input  logic [2:0] Q_out,
  output logic       Request,
  output logic       Done,
  output logic       add_s,
  output logic       sub_s,
  output logic       ashift_s,
  output logic       Busy,
  output logic       Valid
);

  localparam int CNT_W = cnt_width(N_BIT);

  booth_state_t     r_state;
  booth_state_t     w_next;
  logic             r_request;
  logic             r_done;
  logic             r_busy;
  logic             r_valid;
  logic             r_ashift;
  logic [CNT_W-1:0] w_count;
  logic             w_zero;
  logic             w_last;
  logic             w_unused_q2;

  // Q_out[2] is a datapath bit that carries no meaning for the decode.
  assign w_unused_q2 = Q_out[2] ^ w_zero ^ (^w_count);

  booth_cnt #(
    .N_BIT (N_BIT),
    .CNT_W (CNT_W)
  ) u_cnt (
    .Clock   (Clock),
    .nReset  (nReset),
    .i_load  (r_state == LOAD),
    .i_dec   (r_state == SHIFT),
    .o_count (w_count),
    .o_zero  (w_zero),
    .o_last  (w_last)
  );

  // Next-state logic; Start is only looked at in IDLE, so requests while busy are dropped.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = Start ? LOAD : IDLE;
      LOAD:    w_next = EVAL;
      EVAL:    w_next = SHIFT;
      SHIFT:   w_next = w_last ? FIN : EVAL;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register with Moore outputs registered from the next state.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state   <= IDLE;
      r_request <= 1'b0;
      r_done    <= 1'b1;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_ashift  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_request <= (w_next == LOAD) || (w_next == EVAL) || (w_next == SHIFT);
      r_done    <= (w_next == IDLE) || (w_next == LOAD) || (w_next == FIN);
      r_busy    <= (w_next == LOAD) || (w_next == EVAL) || (w_next == SHIFT);
      r_valid   <= (w_next == FIN);
      r_ashift  <= (w_next == SHIFT);
    end
  end

  // Add/subtract follow the live multiplier pair during EVAL; the two codes are exclusive.
  assign add_s    = (r_state == EVAL) && (Q_out[1:0] == QP_ADD);
  assign sub_s    = (r_state == EVAL) && (Q_out[1:0] == QP_SUB);

  assign Request  = r_request;
  assign Done     = r_done;
  assign Busy     = r_busy;
  assign Valid    = r_valid;
  assign ashift_s = r_ashift;

endmodule

// File: tb/tb_booth_ctrl.sv
// Scoreboard bench for booth_ctrl closed around a behavioural Booth datapath.
module tb_booth_ctrl;

  localparam int N   = 8;
  localparam int LAT = 2 * N + 1;  // edges from the Start-sampling edge to the edge entering FIN

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       Start = 1'b0;
  logic [2:0] Q_out;
  logic       Request, Done, add_s, sub_s, ashift_s, Busy, Valid;

  booth_ctrl #(.N_BIT(N)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Start    (Start),
    .Q_out    (Q_out),
    .Request  (Request),
    .Done     (Done),
    .add_s    (add_s),
    .sub_s    (sub_s),
    .ashift_s (ashift_s),
    .Busy     (Busy),
    .Valid    (Valid)
  );

  always #5 Clock = ~Clock;

  // ---------------- checking counters ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint act, input longint req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // ---------------- behavioural datapath (guard bit on A) ----------------
  logic [N-1:0]      op1 = '0, op2 = '0;
  logic signed [N:0] dp_a, dp_m;
  logic [N-1:0]      dp_q;
  logic              dp_qm1;
  bit                open_loop = 0;
  logic [2:0]        q_force = '0;
  logic [2*N-1:0]    result;

  always @(posedge Clock) begin
    if (Request && Done) begin
      dp_a   <= '0;
      dp_m   <= {op1[N-1], op1};
      dp_q   <= op2;
      dp_qm1 <= 1'b0;
    end else if (add_s) begin
      dp_a <= dp_a + dp_m;
    end else if (sub_s) begin
      dp_a <= dp_a - dp_m;
    end else if (ashift_s) begin
      {dp_a, dp_q, dp_qm1} <= {dp_a[N], dp_a, dp_q};
    end
  end

  assign Q_out  = open_loop ? q_force : {dp_q[1], dp_q[0], dp_qm1};
  assign result = {dp_a[N-1:0], dp_q};

  // ---------------- reference model / scoreboard producer ----------------
  typedef struct {
    logic [2*N-1:0] res;
    bit             chk_res;
    int             fin_edge;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   next_accept = 0;

  // A Start seen at an edge while the model is idle begins one multiply; anything else is dropped.
  always @(posedge Clock) begin
    int   k;
    int   prod;
    exp_t e;
    k = cyc + 1;
    cyc <= k;
    if (!nReset) begin
      sb_q.delete();
      next_accept <= 0;
    end else if (Start && (k >= next_accept)) begin
      prod      = int'($signed(op1)) * int'($signed(op2));
      e.res     = prod[2*N-1:0];
      e.chk_res = !open_loop;
      e.fin_edge = k + LAT;
      sb_q.push_back(e);
      next_accept <= k + LAT + 2;  // FIN, then one IDLE cycle
    end
  end

  // ---------------- monitor ----------------
  int evals = 0, shifts = 0, proto_err = 0, valid_cnt = 0;
  int valid_cycs[$];

  always @(negedge Clock) begin
    int   pend;
    exp_t e;
    if (nReset) begin
      if (Request && Done) begin evals = 0; shifts = 0; end
      if (Request && !Done && !ashift_s) evals++;
      if (ashift_s) shifts++;
      if (add_s && sub_s) proto_err++;
      if ((add_s || sub_s) && !(Request && !Done && !ashift_s)) proto_err++;
      if (Busy != Request) proto_err++;
      if (Valid && (Request || !Done)) proto_err++;
      if (Valid) begin
        valid_cnt++;
        valid_cycs.push_back(cyc);
        pend = sb_q.size();
        check("pending_on_valid", pend > 0, 1);
        if (pend > 0) begin
          e = sb_q.pop_front();
          check("valid_cycle", cyc, e.fin_edge);
          if (e.chk_res) check("result", result, e.res);
          check("eval_count", evals, N);
          check("shift_count", shifts, N);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (sb_q.size() == 0 && !Busy && !Valid) begin ok = 1; break; end
    end
    check("wait_idle", ok, 1);
  endtask

  task automatic wait_eval();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (Request && !Done && !ashift_s) begin ok = 1; break; end
    end
    check("wait_eval", ok, 1);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge Clock);
    op1 = a; op2 = b; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] pats [4];
    int         v0, gap;
    int         idle_bad;
    pats[0] = 2'b01; pats[1] = 2'b10; pats[2] = 2'b00; pats[3] = 2'b11;

    // reset state
    repeat (3) @(negedge Clock);
    check("rst_request", Request, 0);
    check("rst_done", Done, 1);
    check("rst_strobes", {add_s, sub_s, ashift_s}, 0);
    check("rst_busy", Busy, 0);
    check("rst_valid", Valid, 0);
    nReset = 1'b1;

    // directed closed-loop products
    run_op(8'd15, 8'd23);
    check("res_15x23", result, 16'd345);
    run_op(8'hF1, 8'd23);
    check("res_m15x23", result, 16'hFEA7);
    run_op(8'h80, 8'h80);
    check("res_m128sq", result, 16'h4000);
    run_op(8'h7F, 8'h80);
    run_op(8'h00, 8'hFF);

    // random closed-loop products
    repeat (20) run_op(N'($urandom), N'($urandom));

    // Start again mid-operation is ignored
    v0 = valid_cnt;
    @(negedge Clock);
    op1 = 8'd9; op2 = 8'd7; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_eval();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle();
    repeat (25) @(negedge Clock);
    check("single_op_on_restart", valid_cnt - v0, 1);

    // open loop: forced Q pairs in successive EVAL cycles
    open_loop = 1;
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_eval();
      q_force = {1'($urandom), pats[i]};
      #1;
      $display("open-loop eval %0d: Q_out=%b add_s=%b sub_s=%b", i, q_force, add_s, sub_s);
      check("ol_add", add_s, pats[i] == 2'b01);
      check("ol_sub", sub_s, pats[i] == 2'b10);
    end
    wait_idle();
    open_loop = 0;

    // Start held high: back-to-back operations with one IDLE between
    valid_cycs.delete();
    @(negedge Clock);
    op1 = 8'd15; op2 = 8'd23; Start = 1'b1;
    repeat (40) @(negedge Clock);
    Start = 1'b0;
    wait_idle();
    gap = (valid_cycs.size() >= 2) ? valid_cycs[1] - valid_cycs[0] : -1;
    check("b2b_valid_gap", gap, LAT + 2);

    // asynchronous reset in the middle of EVAL
    @(negedge Clock);
    op1 = 8'd15; op2 = 8'd23; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_eval();
    #2 nReset = 1'b0;
    #1;
    check("arst_strobes", {add_s, sub_s, ashift_s}, 0);
    check("arst_done", Done, 1);
    check("arst_busy", Busy, 0);
    check("arst_request", Request, 0);
    check("arst_valid", Valid, 0);
    @(negedge Clock);
    nReset = 1'b1;
    idle_bad = 0;
    repeat (10) begin
      @(negedge Clock);
      if (Busy || Request || add_s || sub_s || ashift_s || Valid) idle_bad++;
    end
    check("idle_after_reset", idle_bad, 0);
    run_op(8'd15, 8'd23);
    check("res_after_reset", result, 16'd345);

    check("protocol_errors", proto_err, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
